// File: rtl/sq_sum_odd.sv
// sq_sum_odd
// Sequential producer for the odd-number square-root stage. Computes
// S = X^2 + Y^2 by adding successive odd numbers (n^2 = 1 + 3 + ... + (2n-1)),
// then presents S saturated to W_OUT bits so the downstream W_OUT -> W_IN
// sqrt stage yields an integer Euclidean magnitude.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   X/Y valid            in_ready   operands can be accepted
//   X, Y       unsigned operands (W_IN bits)
//   out_valid  I/sat valid          out_ready  downstream accepts result
//   I          min(X^2 + Y^2, 2^W_OUT - 1)
//   sat        result was clipped
//
// Latency: out_valid rises X+Y+2 rising edges after the accepting edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// ACC_X | adding X successive odd numbers into the accumulator
// ACC_Y | adding Y successive odd numbers, then register the result
// DONE  | result held stable until out_valid & out_ready

module sq_sum_odd #(
    parameter int W_IN  = 4,
    parameter int W_OUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  X,
    input  logic [W_IN-1:0]  Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] I,
    output logic             sat
);

    localparam int W_ACC = W_OUT + 2;
    localparam int W_ODD = W_IN + 2;

    localparam logic [W_ACC-1:0] SAT_LIM  = W_ACC'((1 << W_OUT) - 1);
    localparam logic [W_ODD-1:0] ODD_ONE  = W_ODD'(1);
    localparam logic [W_ODD-1:0] ODD_STEP = W_ODD'(2);
    localparam logic [W_IN-1:0]  CNT_ONE  = W_IN'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_X = 2'd1,
        ACC_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W_ACC-1:0]   acc_q, acc_d;
    logic [W_ODD-1:0]   odd_q, odd_d;
    logic [W_IN-1:0]    cnt_q, cnt_d;
    logic [W_IN-1:0]    y_q, y_d;
    logic [W_OUT-1:0]   i_q, i_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;
    logic [W_ACC-1:0]   acc_sum;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        odd_d       = odd_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        i_d         = i_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        in_ready    = (state_q == IDLE);
        acc_sum     = acc_q + W_ACC'(odd_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // X goes straight into the counter; only Y needs holding.
                    cnt_d   = X;
                    y_d     = Y;
                    acc_d   = '0;
                    odd_d   = ODD_ONE;
                    state_d = ACC_X;
                end
            end
            ACC_X: begin
                if (cnt_q != '0) begin
                    acc_d = acc_sum;
                    odd_d = odd_q + ODD_STEP;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    odd_d   = ODD_ONE;
                    cnt_d   = y_q;
                    state_d = ACC_Y;
                end
            end
            ACC_Y: begin
                if (cnt_q != '0) begin
                    acc_d = acc_sum;
                    odd_d = odd_q + ODD_STEP;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                    if (acc_q > SAT_LIM) begin
                        i_d   = '1;
                        sat_d = 1'b1;
                    end else begin
                        i_d   = acc_q[W_OUT-1:0];
                        sat_d = 1'b0;
                    end
                end
            end
            DONE: begin
                // I and sat intentionally keep their value after retiring.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            odd_q       <= ODD_ONE;
            cnt_q       <= '0;
            y_q         <= '0;
            i_q         <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            odd_q       <= odd_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            i_q         <= i_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign I         = i_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_sq_sum_odd.sv
// Testbench for sq_sum_odd. A driver issues operand pairs and pushes the
// expected result (from plain arithmetic) into a queue; a monitor pops and
// compares whenever a new result appears, also checking latency, hold
// stability under backpressure and the retire behaviour.

module tb_sq_sum_odd;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] X         = '0;
    logic [3:0] Y         = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] I;
    logic       sat;

    sq_sum_odd #(.W_IN(4), .W_OUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .I         (I),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far (readable race-free at negedge).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int x;
        int y;
        int i;
        int sat;
        int acc_edge;
    } exp_t;

    exp_t exp_q[$];
    int   bp_next  = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: sample at negedge, then choose out_ready for the next edge.
    initial begin
        bit         prev_v  = 1'b0;
        bit         prev_hs = 1'b0;
        logic [7:0] prev_i  = '0;
        logic       prev_s  = 1'b0;
        int         bp_cnt  = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v    = 1'b0;
                prev_hs   = 1'b0;
                bp_cnt    = 0;
                out_ready = 1'b1;
                continue;
            end
            if (prev_hs) begin
                chk("retire_out_valid", int'(out_valid), 0);
                chk("retire_in_ready", int'(in_ready), 1);
            end
            if (out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", int'(out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("I(%0d,%0d)", e.x, e.y), int'(I), e.i);
                    chk($sformatf("sat(%0d,%0d)", e.x, e.y), int'(sat), e.sat);
                    chk($sformatf("latency(%0d,%0d)", e.x, e.y), cyc - e.acc_edge, e.x + e.y + 2);
                end
                bp_cnt  = bp_next;
                bp_next = 0;
            end else if (out_valid && prev_v) begin
                chk("hold_I", int'(I), int'(prev_i));
                chk("hold_sat", int'(sat), int'(prev_s));
            end
            prev_v = out_valid;
            prev_i = I;
            prev_s = sat;
            if (bp_cnt > 0) begin
                out_ready = 1'b0;
                bp_cnt--;
            end else begin
                out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prev_hs = out_valid && out_ready;
        end
    end

    task automatic do_op(input int x, input int y, input int bp);
        int   t = 0;
        int   s;
        exp_t e;
        @(negedge clk);
        X        = 4'(x);
        Y        = 4'(y);
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        s          = x * x + y * y;
        e.x        = x;
        e.y        = y;
        e.i        = (s > 255) ? 255 : s;
        e.sat      = (s > 255) ? 1 : 0;
        e.acc_edge = cyc + 1;
        exp_q.push_back(e);
        bp_next    = bp;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands after capture; the result must not change.
        X = 4'($urandom_range(0, 15));
        Y = 4'($urandom_range(0, 15));
        chk("in_ready_drop", int'(in_ready), 0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_I", int'(I), 0);
        chk("rst_sat", int'(sat), 0);
        rst_n = 1'b1;

        do_op(3, 4, 0);
        do_op(0, 0, 0);
        do_op(15, 0, 0);
        do_op(11, 11, 0);
        do_op(12, 11, 0);
        do_op(15, 15, 0);

        // Backpressure with stray in_valid pulses during ACC and DONE.
        do_op(5, 5, 6);
        repeat (3) @(negedge clk);
        X = 4'd1; Y = 4'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("bp_result_timeout", int'(out_valid), 1);
        X = 4'd1; Y = 4'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        do_op(2, 3, 0);
        drain();

        // Reset in the middle of an accumulation.
        do_op(15, 15, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_I", int'(I), 0);
        chk("midrst_sat", int'(sat), 0);
        rst_n = 1'b1;
        do_op(2, 1, 0);
        drain();

        // Random operands with random downstream readiness.
        rand_rdy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
